// File: rtl/ttm4_pkg.sv
// Shared constants and types for the TTM4 clock stepper.
// Default rates assume a 50 MHz board clock.
package ttm4_pkg;

    localparam int TTM4_DEBOUNCE_CYCLES = 50000;
    localparam int TTM4_RUN_DIV         = 5000000;

    typedef enum logic {
        STEP_MODE = 1'b0,
        RUN_MODE  = 1'b1
    } mode_e;

endpackage

// File: rtl/ttm4_debounce.sv
// Two-flop synchronizer and debounce counter for one front-panel input.
// Emits the stable level plus registered one-cycle fall/rise strobes.
module ttm4_debounce #(
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_VAL       = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic fall_o,
    output logic rise_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          prev_q;
    logic          fall_q, rise_q;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // prev_q lags stable_q so the strobes land one cycle after the flip
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= RESET_VAL;
            sync2_q  <= RESET_VAL;
            stable_q <= RESET_VAL;
            prev_q   <= RESET_VAL;
            cnt_q    <= '0;
            fall_q   <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            cnt_q    <= cnt_d;
            fall_q   <= prev_q & ~stable_q;
            rise_q   <= ~prev_q & stable_q;
        end
    end

    assign level_o = stable_q;
    assign fall_o  = fall_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/ttm4_clock_stepper.sv
// Front-panel control stage for the TTM4 up/down counter.
// Produces registered CP, nPL and nCE in single-step or free-run mode.
module ttm4_clock_stepper
    import ttm4_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = TTM4_DEBOUNCE_CYCLES,
    parameter int RUN_DIV         = TTM4_RUN_DIV
) (
    input  logic CLK,
    input  logic nRST,
    input  logic nSTEP_BTN,
    input  logic nLOAD_BTN,
    input  logic RUN_SW,
    output logic CP,
    output logic nPL,
    output logic nCE,
    output logic RUN_LED
);

    localparam int DW = $clog2(RUN_DIV);

    logic step_lvl, step_ev, step_rise;
    logic load_lvl, load_ev, load_rise;
    logic run_lvl, run_fall, run_rise;
    logic unused_strobes;

    ttm4_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_VAL      (1'b1)
    ) u_step (
        .clk_i  (CLK),
        .rst_ni (nRST),
        .raw_i  (nSTEP_BTN),
        .level_o(step_lvl),
        .fall_o (step_ev),
        .rise_o (step_rise)
    );

    ttm4_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_VAL      (1'b1)
    ) u_load (
        .clk_i  (CLK),
        .rst_ni (nRST),
        .raw_i  (nLOAD_BTN),
        .level_o(load_lvl),
        .fall_o (load_ev),
        .rise_o (load_rise)
    );

    ttm4_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_VAL      (1'b0)
    ) u_run (
        .clk_i  (CLK),
        .rst_ni (nRST),
        .raw_i  (RUN_SW),
        .level_o(run_lvl),
        .fall_o (run_fall),
        .rise_o (run_rise)
    );

    assign unused_strobes = ^{step_lvl, step_rise, load_lvl,
                              load_rise, run_fall, run_rise};

    mode_e         state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic          cp_q, cp_d;
    logic          npl_q, npl_d;
    logic          nce_q, nce_d;
    logic          stay_run, stay_step, tc;

    always_comb begin
        state_d   = run_lvl ? RUN_MODE : STEP_MODE;
        stay_run  = (state_q == RUN_MODE) && (state_d == RUN_MODE);
        stay_step = (state_q == STEP_MODE) && (state_d == STEP_MODE);
        tc        = stay_run && (div_q == DW'(RUN_DIV - 1));
        div_d     = '0;
        if (stay_run && !tc) begin
            div_d = div_q + 1'b1;
        end
        // a load in the same cycle swallows the count pulse
        cp_d  = (tc || (stay_step && step_ev)) && !load_ev;
        npl_d = !load_ev;
        nce_d = !((state_d == RUN_MODE) || cp_d);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= STEP_MODE;
            div_q   <= '0;
            cp_q    <= 1'b0;
            npl_q   <= 1'b1;
            nce_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cp_q    <= cp_d;
            npl_q   <= npl_d;
            nce_q   <= nce_d;
        end
    end

    assign CP      = cp_q;
    assign nPL     = npl_q;
    assign nCE     = nce_q;
    assign RUN_LED = (state_q == RUN_MODE);

endmodule

// File: tb/tb_ttm4_clock_stepper.sv
// Directed and randomized checks of the clock stepper against a
// window-based model of debounce, events and run-mode timing.
module tb_ttm4_clock_stepper;

    localparam int DEB = 4;
    localparam int DIV = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic nstep = 1'b1;
    logic nload = 1'b1;
    logic run = 1'b0;
    logic cp, npl, nce, led;

    always #5 clk = ~clk;

    ttm4_clock_stepper #(
        .DEBOUNCE_CYCLES(DEB),
        .RUN_DIV        (DIV)
    ) dut (
        .CLK      (clk),
        .nRST     (rst_n),
        .nSTEP_BTN(nstep),
        .nLOAD_BTN(nload),
        .RUN_SW   (run),
        .CP       (cp),
        .nPL      (npl),
        .nCE      (nce),
        .RUN_LED  (led)
    );

    int vectors = 0;
    int errors  = 0;

    // model: raw sample history, newest in bit 0
    bit [DEB+1:0] h_step, h_load, h_run;
    bit s_step, s_load, s_run;
    bit f1s, f2s, f1l, f2l;
    bit m_run;
    int n, e_run;
    bit e_cp, e_npl, e_nce, e_led;
    int cp_count;

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        h_step = '1; h_load = '1; h_run = '0;
        s_step = 1'b1; s_load = 1'b1; s_run = 1'b0;
        f1s = 0; f2s = 0; f1l = 0; f2l = 0;
        m_run = 0; n = 0; e_run = 0;
        e_cp = 0; e_npl = 1; e_nce = 1; e_led = 0;
    endtask

    task automatic model_edge();
        bit ev_s, ev_l, was_run, fl;
        n++;
        ev_s = f2s;
        ev_l = f2l;
        was_run = m_run;
        m_run = s_run;
        if (!was_run && m_run) e_run = n;
        e_cp = !ev_l && ((!was_run && !m_run && ev_s) ||
               (was_run && m_run && ((n - e_run) % DIV == 0)));
        e_npl = !ev_l;
        e_nce = !(m_run || e_cp);
        e_led = m_run;
        // stable flips once DEB synchronized samples all disagree with it
        h_step = {h_step[DEB:0], nstep};
        h_load = {h_load[DEB:0], nload};
        h_run  = {h_run[DEB:0], run};
        fl = (h_step[DEB+1:2] == {DEB{~s_step}});
        if (fl) s_step = ~s_step;
        f2s = f1s; f1s = fl && !s_step;
        fl = (h_load[DEB+1:2] == {DEB{~s_load}});
        if (fl) s_load = ~s_load;
        f2l = f1l; f1l = fl && !s_load;
        fl = (h_run[DEB+1:2] == {DEB{~s_run}});
        if (fl) s_run = ~s_run;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("cp", cp, e_cp);
        chk("npl", npl, e_npl);
        chk("nce", nce, e_nce);
        chk("led", led, e_led);
        if (cp === 1'b1) cp_count++;
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    initial begin
        int first, rise, last, target, hold;
        model_reset();

        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cp", cp, 1'b0);
        chk("rst_npl", npl, 1'b1);
        chk("rst_nce", nce, 1'b1);
        chk("rst_led", led, 1'b0);
        rst_n = 1'b1;
        cp_count = 0;
        ticks(20);
        chk_int("idle_pulses", cp_count, 0);

        // single step press, latency and width
        cp_count = 0;
        first = -1;
        nstep = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (cp === 1'b1 && first < 0) begin
                first = i;
                chk("step_nce", nce, 1'b0);
            end
        end
        chk_int("step_latency", first, 2 + DEB + 2);
        nstep = 1'b1;
        ticks(12);
        chk_int("step_pulses", cp_count, 1);

        // bounce then steady press
        cp_count = 0;
        for (int i = 0; i < 12; i++) begin
            nstep = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
        end
        nstep = 1'b0;
        ticks(12);
        nstep = 1'b1;
        ticks(12);
        chk_int("bounce_pulses", cp_count, 1);

        // short glitch
        cp_count = 0;
        nstep = 1'b0;
        ticks(DEB - 1);
        nstep = 1'b1;
        ticks(15);
        chk_int("glitch_pulses", cp_count, 0);

        // run mode, step presses ignored
        run = 1'b1;
        ticks(2 + DEB + 1);
        chk("run_led", led, 1'b1);
        cp_count = 0;
        last = -1;
        for (int i = 0; i < 5 * DIV + 5; i++) begin
            nstep = (i >= 10 && i < 20) ? 1'b0 : 1'b1;
            tick();
            if (cp === 1'b1) begin
                if (last >= 0) chk_int("run_period", n - last, DIV);
                last = n;
            end
        end
        chk_int("run_pulses", cp_count, 5);

        // load aligned with terminal count
        for (int i = 0; i < DIV; i++) begin
            if (((n + 1 + DEB + 3 - e_run) % DIV) != 0) tick();
        end
        nload = 1'b0;
        target = n + 1 + DEB + 3;
        while (n < target && n < target + 1) tick();
        chk("coll_npl", npl, 1'b0);
        chk("coll_cp", cp, 1'b0);
        first = -1;
        for (int i = 0; i < 2 * DIV && first < 0; i++) begin
            tick();
            if (cp === 1'b1) first = n - target;
        end
        chk_int("coll_next_cp", first, DIV);
        nload = 1'b1;
        ticks(10);

        // reset during a count pulse
        for (int i = 0; i < 2 * DIV && cp !== 1'b1; i++) tick();
        chk("pre_rst_cp", cp, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cp", cp, 1'b0);
        chk("mid_rst_npl", npl, 1'b1);
        chk("mid_rst_nce", nce, 1'b1);
        chk("mid_rst_led", led, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        rise = -1;
        first = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (led === 1'b1 && rise < 0) rise = i;
            if (cp === 1'b1 && first < 0) first = i;
        end
        chk_int("rst_led_rise", rise, 2 + DEB + 1);
        chk_int("rst_first_cp", first, 2 + DEB + 1 + DIV);

        // randomized front-panel activity
        hold = 0;
        for (int i = 0; i < 800; i++) begin
            if (hold == 0) begin
                nstep = 1'($urandom_range(0, 1));
                nload = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
                if ($urandom_range(0, 7) == 0) run = ~run;
                hold = $urandom_range(1, 2 * DEB + 2);
            end
            hold--;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
